duck_sprite_ctrl: RTL

DUCK_SPRITE_CTRL -- requirements
Module: duck_sprite_ctrl

---
 rtl/duck_sprite_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/duck_sprite_ctrl.sv
// duck_sprite_ctrl
//   Moves one duck sprite across a 640x480 screen and produces its pixels.
//   Position and state advance once per frame (frame_start), or on spawn/hit.
//   The ROM address is combinational from the pixel coordinate so the
//   negedge-clocked sprite ROM returns data before the next posedge. There,
//   the ROM data is registered into palette_index/sprite_on.
//
// Ports
//   vga_clk, reset_n        pixel clock, async active-low reset
//   DrawX, DrawY            current pixel coordinate
//   frame_start             one pulse per frame (start of vertical blank)
//   spawn, spawn_x          launch request and start column
//   hit                     duck was shot
//   rom_address / rom_q     sprite ROM address out / palette index in
//   sprite_on, palette_index registered pixel-valid flag and colour
//   state                   FSM state
//   duck_x, duck_y          sprite top-left corner
//   escaped, fell           one-cycle event pulses
//
// state | meaning
// IDLE  | no duck on screen, waiting for spawn
// FLY   | duck flying diagonally, bouncing off the side walls
// SHOT  | duck hit, frozen for SHOT_FRAMES frames
// FALL  | duck dropping to the ground line

module duck_sprite_ctrl #(
  parameter int SPR_W       = 68,
  parameter int SPR_H       = 64,
  parameter int SPEED       = 2,
  parameter int FALL_STEP   = 4,
  parameter int SHOT_FRAMES = 30
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        spawn,
  input  logic [9:0]  spawn_x,
  input  logic        hit,
  output logic [12:0] rom_address,
  input  logic [3:0]  rom_q,
  output logic        sprite_on,
  output logic [3:0]  palette_index,
  output logic [1:0]  state,
  output logic [9:0]  duck_x,
  output logic [9:0]  duck_y,
  output logic        escaped,
  output logic        fell
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    SHOT = 2'd2,
    FALL = 2'd3
  } state_t;

  localparam logic [9:0]         X_MAX  = 10'(640 - SPR_W);
  localparam logic [9:0]         Y_MAX  = 10'(480 - SPR_H);
  localparam logic signed [11:0] NX_MAX = 12'(640 - SPR_W);

  state_t             cur_state;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [4:0]         shot_cnt;

  logic signed [11:0] nx;
  logic signed [11:0] ny;
  logic [10:0]        fall_y;
  logic [4:0]         cnt_next;

  logic               in_box;
  logic [10:0]        x_end;
  logic [10:0]        y_end;
  logic [9:0]         col_raw;
  logic [9:0]         row_raw;
  logic [9:0]         col;

  assign state = cur_state;

  // Signed next-position arithmetic; the extra bits catch underflow past 0.
  assign nx       = $signed({2'b00, duck_x}) + $signed({dx[10], dx});
  assign ny       = $signed({2'b00, duck_y}) + $signed({dy[10], dy});
  assign fall_y   = {1'b0, duck_y} + 11'(FALL_STEP);
  assign cnt_next = shot_cnt + 5'd1;

  // Sprite box hit test, exclusive upper bounds computed one bit wider.
  assign x_end  = {1'b0, duck_x} + 11'(SPR_W);
  assign y_end  = {1'b0, duck_y} + 11'(SPR_H);
  assign in_box = (cur_state != IDLE) &&
                  (DrawX >= duck_x) && ({1'b0, DrawX} < x_end) &&
                  (DrawY >= duck_y) && ({1'b0, DrawY} < y_end);

  assign col_raw = DrawX - duck_x;
  assign row_raw = DrawY - duck_y;
  // Heading left: mirror the sprite so the duck faces its direction of travel.
  assign col     = dx[10] ? (10'(SPR_W - 1) - col_raw) : col_raw;

  assign rom_address = in_box ? (13'(row_raw) * 13'(SPR_W) + 13'(col)) : 13'd0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state     <= IDLE;
      duck_x        <= '0;
      duck_y        <= '0;
      dx            <= 11'(SPEED);
      dy            <= 11'(-SPEED);
      shot_cnt      <= '0;
      sprite_on     <= 1'b0;
      palette_index <= '0;
      escaped       <= 1'b0;
      fell          <= 1'b0;
    end else begin
      escaped       <= 1'b0;
      fell          <= 1'b0;
      palette_index <= rom_q;
      sprite_on     <= in_box && (rom_q != 4'd0);

      case (cur_state)
        IDLE: begin
          if (spawn) begin
            duck_x    <= (spawn_x > X_MAX) ? X_MAX : spawn_x;
            duck_y    <= Y_MAX;
            dx        <= 11'(SPEED);
            dy        <= 11'(-SPEED);
            cur_state <= FLY;
          end
        end

        FLY: begin
          // A hit in the same cycle as frame_start freezes the duck where it is.
          if (hit) begin
            shot_cnt  <= '0;
            cur_state <= SHOT;
          end else if (frame_start) begin
            if (nx < 12'sd0) begin
              duck_x <= '0;
              dx     <= -dx;
            end else if (nx > NX_MAX) begin
              duck_x <= X_MAX;
              dx     <= -dx;
            end else begin
              duck_x <= nx[9:0];
            end

            if (ny <= 12'sd0) begin
              duck_y    <= '0;
              escaped   <= 1'b1;
              cur_state <= IDLE;
            end else begin
              duck_y <= ny[9:0];
            end
          end
        end

        SHOT: begin
          if (frame_start) begin
            shot_cnt <= cnt_next;
            if (cnt_next == 5'(SHOT_FRAMES)) begin
              cur_state <= FALL;
            end
          end
        end

        FALL: begin
          if (frame_start) begin
            if (fall_y >= {1'b0, Y_MAX}) begin
              duck_y    <= Y_MAX;
              fell      <= 1'b1;
              cur_state <= IDLE;
            end else begin
              duck_y <= fall_y[9:0];
            end
          end
        end

        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule
